// File: rtl/c3demo_pkg.sv
// Shared types and constants for the c3demo RasPi link send path.
package c3demo_pkg;

    localparam int EP_W_DEFAULT        = 8;
    localparam int MAX_BURST_UNLIMITED = 0;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/c3demo_rr_pick.sv
// Rotate-priority encoder: first asserted request at or above ptr, wrapping.
module c3demo_rr_pick #(
    parameter int NUM_EP = 4,
    parameter int IW     = (NUM_EP > 1) ? $clog2(NUM_EP) : 1
) (
    input  logic [NUM_EP-1:0] req,
    input  logic [IW-1:0]     ptr,
    output logic [NUM_EP-1:0] onehot,
    output logic [IW-1:0]     index,
    output logic              any
);

    int          j;
    logic [IW-1:0] jj;

    always_comb begin
        onehot = '0;
        index  = '0;
        any    = 1'b0;
        j      = 0;
        jj     = '0;
        for (int k = 0; k < NUM_EP; k++) begin
            j = int'(ptr) + k;
            if (j >= NUM_EP) begin
                j = j - NUM_EP;
            end
            jj = IW'(j);
            if (!any && req[jj]) begin
                any        = 1'b1;
                onehot[jj] = 1'b1;
                index      = jj;
            end
        end
    end

endmodule

// File: rtl/c3demo_ep_arbiter.sv
// Round-robin send arbiter with packet locking and bounded bursts,
// feeding a registered {epnum, data, last} beat into the send FIFO.
module c3demo_ep_arbiter
    import c3demo_pkg::*;
#(
    parameter int NUM_EP    = 4,
    parameter int DATA_W    = 8,
    parameter int EP_W      = EP_W_DEFAULT,
    parameter int MAX_BURST = 16
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     flush,
    input  logic [NUM_EP-1:0]        s_valid,
    output logic [NUM_EP-1:0]        s_ready,
    input  logic [NUM_EP*DATA_W-1:0] s_data,
    input  logic [NUM_EP-1:0]        s_last,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [DATA_W-1:0]        m_data,
    output logic [EP_W-1:0]          m_epnum,
    output logic                     m_last,
    output logic                     busy
);

    localparam int IW = (NUM_EP > 1) ? $clog2(NUM_EP) : 1;
    localparam int CW = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
    // With no burst limit the counter simply saturates at all-ones.
    localparam logic [CW-1:0] CNT_MAX = (MAX_BURST > 0) ? CW'(MAX_BURST) : '1;

    arb_state_t      state, state_next;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   grant;
    logic [CW-1:0]   beat_cnt;
    logic [CW-1:0]   cnt_inc;
    logic [NUM_EP-1:0] pick_onehot;
    logic [IW-1:0]   pick_index;
    logic            pick_any;
    logic            space;
    logic            accept;
    logic [IW-1:0]   sel;
    logic            sel_last;
    logic            burst_hit;
    logic            done;

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
        return (int'(i) == NUM_EP - 1) ? '0 : i + 1'b1;
    endfunction

    c3demo_rr_pick #(
        .NUM_EP (NUM_EP),
        .IW     (IW)
    ) u_pick (
        .req    (s_valid),
        .ptr    (rr_ptr),
        .onehot (pick_onehot),
        .index  (pick_index),
        .any    (pick_any)
    );

    always_comb begin
        space    = !m_valid || m_ready;
        sel      = (state == LOCKED) ? grant : pick_index;
        accept   = |(s_valid & s_ready);
        sel_last = s_last[sel];
        cnt_inc  = (beat_cnt == CNT_MAX) ? beat_cnt : beat_cnt + 1'b1;
        // beat_cnt is 0 in IDLE, so MAX_BURST==1 releases on the first beat.
        burst_hit = (MAX_BURST != MAX_BURST_UNLIMITED) && (cnt_inc == CNT_MAX);
        done     = sel_last || burst_hit;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = IDLE;
        end else if (accept) begin
            case (state)
                IDLE:    state_next = done ? IDLE : LOCKED;
                LOCKED:  state_next = done ? IDLE : LOCKED;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        s_ready = '0;
        busy    = (state == LOCKED);
        if (resetn && !flush && space) begin
            case (state)
                IDLE:    s_ready = pick_any ? pick_onehot : '0;
                LOCKED:  s_ready[grant] = 1'b1;
                default: s_ready = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rr_ptr   <= '0;
            grant    <= '0;
            beat_cnt <= '0;
        end else if (flush) begin
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else if (accept) begin
            if (done) begin
                rr_ptr   <= next_idx(sel);
                beat_cnt <= '0;
            end else begin
                grant    <= sel;
                beat_cnt <= cnt_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_epnum <= '0;
            m_last  <= 1'b0;
        end else if (flush) begin
            m_valid <= 1'b0;
        end else if (accept) begin
            m_valid <= 1'b1;
            m_data  <= s_data[int'(sel) * DATA_W +: DATA_W];
            m_epnum <= EP_W'(sel);
            m_last  <= sel_last;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_c3demo_ep_arbiter.sv
// Bench for c3demo_ep_arbiter: per-endpoint beat sources, an ordered expected
// queue of output beats, a ready-vector table and multi-cycle corner sequences.
module tb_c3demo_ep_arbiter;

    localparam int NUM_EP    = 4;
    localparam int DATA_W    = 8;
    localparam int EP_W      = 8;
    localparam int MAX_BURST = 4;
    localparam int W         = EP_W + DATA_W + 1;

    logic                     clk = 1'b0;
    logic                     resetn;
    logic                     flush;
    logic [NUM_EP-1:0]        s_valid;
    logic [NUM_EP-1:0]        s_ready;
    logic [NUM_EP*DATA_W-1:0] s_data;
    logic [NUM_EP-1:0]        s_last;
    logic                     m_valid;
    logic                     m_ready;
    logic [DATA_W-1:0]        m_data;
    logic [EP_W-1:0]          m_epnum;
    logic                     m_last;
    logic                     busy;

    c3demo_ep_arbiter #(
        .NUM_EP    (NUM_EP),
        .DATA_W    (DATA_W),
        .EP_W      (EP_W),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk     (clk),
        .resetn  (resetn),
        .flush   (flush),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_last  (s_last),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_epnum (m_epnum),
        .m_last  (m_last),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    logic [DATA_W-1:0] src_data  [NUM_EP][16];
    logic              src_lastv [NUM_EP][16];
    int                src_len   [NUM_EP];
    int                src_rd    [NUM_EP];
    logic [NUM_EP-1:0] gap;
    logic [NUM_EP-1:0] acc;
    int                busy_seen;
    int                used;

    typedef struct {
        logic              fl;
        logic              mr;
        logic [NUM_EP-1:0] v;
        logic [NUM_EP-1:0] er;
    } vec_t;
    vec_t vt[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add_src(input int ep, input logic [DATA_W-1:0] d, input logic l);
        if (src_rd[ep] == src_len[ep]) begin
            src_rd[ep]  = 0;
            src_len[ep] = 0;
        end
        src_data[ep][src_len[ep]]  = d;
        src_lastv[ep][src_len[ep]] = l;
        src_len[ep]++;
    endtask

    task automatic expect_beat(input int ep, input logic [DATA_W-1:0] d, input logic l);
        exp_q.push_back({EP_W'(ep), d, l});
    endtask

    task automatic clear_srcs();
        for (int i = 0; i < NUM_EP; i++) begin
            src_rd[i]  = 0;
            src_len[i] = 0;
        end
    endtask

    function automatic bit srcs_empty();
        for (int i = 0; i < NUM_EP; i++) begin
            if (src_rd[i] < src_len[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic drive();
        for (int i = 0; i < NUM_EP; i++) begin
            if (src_rd[i] < src_len[i]) begin
                s_valid[i]                  = !gap[i];
                s_data[i*DATA_W +: DATA_W]  = src_data[i][src_rd[i]];
                s_last[i]                   = src_lastv[i][src_rd[i]];
            end else begin
                s_valid[i]                  = 1'b0;
                s_data[i*DATA_W +: DATA_W]  = '0;
                s_last[i]                   = 1'b0;
            end
        end
    endtask

    // Called just after a falling edge: drive, settle, then score any beat
    // the downstream takes at the coming rising edge.
    task automatic pre();
        logic [W-1:0] e;
        drive();
        #1;
        acc = s_valid & s_ready;
        if (busy) busy_seen++;
        if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got 0x%0h expected none", {m_epnum, m_data, m_last});
            end else begin
                e = exp_q.pop_front();
                chk("out_beat", {15'b0, m_epnum, m_data, m_last}, {15'b0, e});
            end
        end
    endtask

    task automatic post();
        @(posedge clk);
        for (int i = 0; i < NUM_EP; i++) begin
            if (acc[i]) src_rd[i]++;
        end
        @(negedge clk);
    endtask

    task automatic cycle();
        pre();
        post();
    endtask

    task automatic drain(input string name, input int budget, output int n);
        n = 0;
        while (!(exp_q.size() == 0 && srcs_empty())) begin
            if (n >= budget) begin
                checks++;
                errors++;
                $display("FAIL %s_timeout: got %0d pending beats expected 0", name, exp_q.size());
                exp_q.delete();
                clear_srcs();
                break;
            end
            cycle();
            n++;
        end
    endtask

    task automatic run_until_rd(input string name, input int ep, input int n, input int budget);
        int c;
        c = 0;
        while (src_rd[ep] < n) begin
            if (c >= budget) begin
                checks++;
                errors++;
                $display("FAIL %s_timeout: got %0d accepted expected %0d", name, src_rd[ep], n);
                break;
            end
            cycle();
            c++;
        end
    endtask

    task automatic do_reset();
        resetn  = 1'b0;
        flush   = 1'b0;
        gap     = '0;
        s_valid = '0;
        clear_srcs();
        exp_q.delete();
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        resetn  = 1'b0;
        flush   = 1'b0;
        m_ready = 1'b1;
        s_valid = '0;
        s_data  = '0;
        s_last  = '0;
        gap     = '0;
        clear_srcs();

        repeat (3) @(negedge clk);
        #1;
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_epnum", m_epnum, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_s_ready", s_ready, 0);
        @(negedge clk);
        resetn = 1'b1;

        // Ready vector from IDLE with rr_ptr=0; inputs pulled back before each edge.
        vt[0] = '{1'b0, 1'b1, 4'b0000, 4'b0000};
        vt[1] = '{1'b0, 1'b1, 4'b0001, 4'b0001};
        vt[2] = '{1'b0, 1'b1, 4'b1010, 4'b0010};
        vt[3] = '{1'b0, 1'b1, 4'b1000, 4'b1000};
        vt[4] = '{1'b0, 1'b1, 4'b1111, 4'b0001};
        vt[5] = '{1'b1, 1'b1, 4'b1111, 4'b0000};
        vt[6] = '{1'b0, 1'b0, 4'b1100, 4'b0100};
        vt[7] = '{1'b0, 1'b1, 4'b0110, 4'b0010};
        for (int r = 0; r < 8; r++) begin
            @(negedge clk);
            flush   = vt[r].fl;
            m_ready = vt[r].mr;
            s_valid = vt[r].v;
            #1;
            chk($sformatf("ready_vec%0d", r), s_ready, vt[r].er);
            #1;
            s_valid = '0;
            flush   = 1'b0;
            m_ready = 1'b1;
        end
        @(negedge clk);

        // Single endpoint: three beats, consecutive outputs, two LOCKED cycles.
        add_src(2, 8'h11, 1'b0);
        add_src(2, 8'h22, 1'b0);
        add_src(2, 8'h33, 1'b1);
        expect_beat(2, 8'h11, 1'b0);
        expect_beat(2, 8'h22, 1'b0);
        expect_beat(2, 8'h33, 1'b1);
        busy_seen = 0;
        drain("single", 20, used);
        chk("single_cycles", used, 4);
        chk("single_busy_cycles", busy_seen, 2);

        // Round robin with all endpoints holding single-beat packets.
        do_reset();
        for (int ep = 0; ep < NUM_EP; ep++) begin
            for (int k = 0; k < 2; k++) begin
                add_src(ep, DATA_W'(8'h40 + ep * 16 + k), 1'b1);
            end
        end
        for (int k = 0; k < 2; k++) begin
            for (int ep = 0; ep < NUM_EP; ep++) begin
                expect_beat(ep, DATA_W'(8'h40 + ep * 16 + k), 1'b1);
            end
        end
        drain("rr", 40, used);
        chk("rr_cycles", used, 9);

        // Packet lock: move rr_ptr to 1, then ep1 packet with a 2-cycle gap.
        add_src(0, 8'hA0, 1'b1);
        expect_beat(0, 8'hA0, 1'b1);
        drain("lock_pre", 10, used);
        for (int k = 0; k < 4; k++) begin
            add_src(1, DATA_W'(8'hB0 + k), k == 3);
            expect_beat(1, DATA_W'(8'hB0 + k), k == 3);
        end
        add_src(0, 8'hC0, 1'b1);
        expect_beat(0, 8'hC0, 1'b1);
        run_until_rd("lock", 1, 2, 10);
        gap[1] = 1'b1;
        repeat (2) begin
            pre();
            chk("lock_gap_ep0_ready", s_ready[0], 0);
            chk("lock_gap_busy", busy, 1);
            post();
        end
        gap = '0;
        drain("lock", 20, used);

        // Burst limit of 4: ep3 cut, ep0 slips in, ep3 resumes.
        for (int k = 0; k < 10; k++) begin
            add_src(3, DATA_W'(8'h30 + k), 1'b0);
        end
        add_src(0, 8'hE0, 1'b1);
        for (int k = 0; k < 4; k++) expect_beat(3, DATA_W'(8'h30 + k), 1'b0);
        expect_beat(0, 8'hE0, 1'b1);
        for (int k = 4; k < 10; k++) expect_beat(3, DATA_W'(8'h30 + k), 1'b0);
        drain("burst", 40, used);
        chk("burst_still_locked", busy, 1);

        // flush: clears the lock, then aborts a packet after its second beat.
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        chk("flush1_busy", busy, 0);
        chk("flush1_m_valid", m_valid, 0);
        add_src(1, 8'h51, 1'b1);
        expect_beat(1, 8'h51, 1'b1);
        drain("flush_pre", 10, used);
        for (int k = 0; k < 4; k++) add_src(2, DATA_W'(8'hF0 + k), k == 3);
        expect_beat(2, 8'hF0, 1'b0);
        expect_beat(2, 8'hF1, 1'b0);
        run_until_rd("flush", 2, 2, 10);
        flush       = 1'b1;
        src_len[2]  = src_rd[2];
        add_src(1, 8'h61, 1'b1);
        add_src(3, 8'h63, 1'b1);
        pre();
        chk("flush2_s_ready", s_ready, 0);
        post();
        flush = 1'b0;
        chk("flush2_busy", busy, 0);
        chk("flush2_m_valid", m_valid, 0);
        expect_beat(1, 8'h61, 1'b1);
        expect_beat(3, 8'h63, 1'b1);
        drain("flush_post", 10, used);

        // Backpressure for 5 cycles mid-packet.
        for (int k = 0; k < 5; k++) begin
            add_src(0, DATA_W'(8'h70 + k), k == 4);
            expect_beat(0, DATA_W'(8'h70 + k), k == 4);
        end
        run_until_rd("bp", 0, 2, 10);
        m_ready = 1'b0;
        repeat (5) begin
            pre();
            chk("bp_m_valid", m_valid, 1);
            chk("bp_m_data", m_data, 8'h71);
            chk("bp_m_epnum", m_epnum, 0);
            chk("bp_s_ready", s_ready, 0);
            post();
        end
        m_ready = 1'b1;
        drain("bp", 20, used);
        repeat (3) cycle();

        // Asynchronous reset between edges, mid-packet.
        for (int k = 0; k < 4; k++) add_src(1, DATA_W'(8'h90 + k), k == 3);
        expect_beat(1, 8'h90, 1'b0);
        run_until_rd("rst", 1, 2, 10);
        #2;
        resetn = 1'b0;
        #1;
        chk("arst_m_valid", m_valid, 0);
        chk("arst_m_data", m_data, 0);
        chk("arst_m_epnum", m_epnum, 0);
        chk("arst_m_last", m_last, 0);
        chk("arst_busy", busy, 0);
        chk("arst_s_ready", s_ready, 0);
        chk("arst_first_beat_seen", exp_q.size(), 0);
        clear_srcs();
        exp_q.delete();
        s_valid = '0;
        @(negedge clk);
        resetn = 1'b1;
        add_src(2, 8'hAA, 1'b1);
        expect_beat(2, 8'hAA, 1'b1);
        drain("after_rst", 10, used);
        chk("after_rst_cycles", used, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
